steer_en: RTL

Rider-detect and steering-enable stage, directly upstream of the balance controller. Samples the left and right load-cell readings and produces three outputs for the controller:
- rider_off, with hysteresis.
- en_steer, qualified by a settling timer and a balance check.
- a saturated signed load-cell difference used as the steering term.
Operates in the 50 MHz clk domain. A new load-cell sample is marked by vld.

---
 rtl/segway_pkg.sv | 28 ++
 rtl/steer_tmr.sv | 27 ++
 rtl/steer_en.sv | 115 +++++++++++
 3 files changed

// File: rtl/segway_pkg.sv
// Shared types and default constants for the Segway rider-detect / steering-enable slice.
package segway_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STEER = 2'd2
   } steer_state_t;

   localparam logic [11:0] DFLT_MIN_RIDER_WT  = 12'h200;
   localparam logic [7:0]  DFLT_WT_HYSTERESIS = 8'h40;

   localparam int unsigned TMR_W_FAST = 15;
   localparam int unsigned TMR_W      = 26;

   // Clamp a 13-bit two's-complement value into the 12-bit signed range.
   function automatic logic [11:0] sat12(input logic [12:0] d);
      logic [11:0] r;
      if (d[12] && !d[11])
         r = 12'h800;
      else if (!d[12] && d[11])
         r = 12'h7FF;
      else
         r = d[11:0];
      return r;
   endfunction

endpackage

// File: rtl/steer_tmr.sv
// Settling timer for steer_en: 26-bit up-counter with clear/increment and a full flag.
module steer_tmr
   import segway_pkg::*;
#(
   parameter bit FAST_SIM = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic tmr_full
);

   logic [TMR_W-1:0] tmr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmr <= '0;
      else if (clr)
         tmr <= '0;
      else if (inc)
         tmr <= tmr + 1'b1;
   end

   assign tmr_full = FAST_SIM ? (&tmr[TMR_W_FAST-1:0]) : (&tmr);

endmodule

// File: rtl/steer_en.sv
// Rider-detect and steering-enable stage: captures load cells, derives rider_off with
// hysteresis, qualifies en_steer with a settling timer and balance checks.
module steer_en
   import segway_pkg::*;
#(
   parameter bit          FAST_SIM      = 1'b0,
   parameter logic [11:0] MIN_RIDER_WT  = DFLT_MIN_RIDER_WT,
   parameter logic [7:0]  WT_HYSTERESIS = DFLT_WT_HYSTERESIS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic [11:0] ld_cell_diff,
   output logic        rider_off,
   output logic        en_steer
);

   steer_state_t state, nxt_state;

   logic [11:0] lft_smp, rght_smp;
   logic [12:0] sum, thr_hi, thr_lo;
   logic [11:0] adiff;
   logic        sum_gt_min, sum_lt_min;
   logic        diff_gt_1_4, diff_gt_15_16;
   logic        tmr_clr, tmr_inc, tmr_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_smp      <= '0;
         rght_smp     <= '0;
         ld_cell_diff <= '0;
      end else if (vld) begin
         lft_smp      <= lft_ld;
         rght_smp     <= rght_ld;
         ld_cell_diff <= sat12({1'b0, lft_ld} - {1'b0, rght_ld});
      end
   end

   always_comb begin
      sum           = {1'b0, lft_smp} + {1'b0, rght_smp};
      adiff         = (lft_smp >= rght_smp) ? (lft_smp - rght_smp) : (rght_smp - lft_smp);
      thr_hi        = {1'b0, MIN_RIDER_WT} + {5'b0, WT_HYSTERESIS};
      thr_lo        = {1'b0, MIN_RIDER_WT} - {5'b0, WT_HYSTERESIS};
      sum_gt_min    = sum > thr_hi;
      sum_lt_min    = sum < thr_lo;
      diff_gt_1_4   = {1'b0, adiff} > (sum >> 2);
      diff_gt_15_16 = {1'b0, adiff} > (sum - (sum >> 4));
   end

   // Readings inside the hysteresis band leave rider_off unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rider_off <= 1'b1;
      else if (sum_lt_min)
         rider_off <= 1'b1;
      else if (sum_gt_min)
         rider_off <= 1'b0;
   end

   always_comb begin
      nxt_state = state;
      tmr_clr   = 1'b0;
      tmr_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (sum_gt_min) begin
               nxt_state = WAIT;
               tmr_clr   = 1'b1;
            end
         end
         WAIT: begin
            if (sum_lt_min)
               nxt_state = IDLE;
            else if (diff_gt_1_4)
               tmr_clr = 1'b1;
            else if (tmr_full)
               nxt_state = STEER;
            else
               tmr_inc = 1'b1;
         end
         STEER: begin
            if (sum_lt_min)
               nxt_state = IDLE;
            else if (diff_gt_15_16) begin
               nxt_state = WAIT;
               tmr_clr   = 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         en_steer <= 1'b0;
      end else begin
         state    <= nxt_state;
         en_steer <= (nxt_state == STEER);
      end
   end

   steer_tmr #(
      .FAST_SIM (FAST_SIM)
   ) u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (tmr_clr),
      .inc      (tmr_inc),
      .tmr_full (tmr_full)
   );

endmodule
